// File: rtl/cr16_cond_unit.sv
// CR16 condition unit: holds the PSR flags, evaluates 4-bit condition codes
// and queues taken/not-taken results for the fetch/branch logic.
module cr16_cond_unit #(
  parameter int DEPTH   = 2,
  parameter int FORWARD = 1
) (
  input  logic       I_CLK,
  input  logic       I_NRESET,
  input  logic [4:0] I_STATUS,
  input  logic       I_STATUS_WE,
  input  logic [4:0] I_PSR_WDATA,
  input  logic       I_PSR_LOAD,
  input  logic [3:0] I_COND,
  input  logic       I_COND_VALID,
  output logic       O_COND_READY,
  output logic       O_TAKE_VALID,
  output logic       O_TAKE,
  input  logic       I_TAKE_READY,
  output logic [4:0] O_PSR,
  output logic [2:0] O_COUNT
);

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [1:0] LAST_C  = 2'(DEPTH - 1);

  // Flag vector layout is {N,Z,F,L,C}.
  function automatic logic cond_eval(input logic [3:0] cc, input logic [4:0] f);
    logic n, z, fl, l, c;
    logic r;
    n  = f[4];
    z  = f[3];
    fl = f[2];
    l  = f[1];
    c  = f[0];
    case (cc)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = c;
      4'b0011: r = !c;
      4'b0100: r = l;
      4'b0101: r = !l;
      4'b0110: r = n;
      4'b0111: r = !n;
      4'b1000: r = fl;
      4'b1001: r = !fl;
      4'b1010: r = !l && !z;
      4'b1011: r = l || z;
      4'b1100: r = !n && !z;
      4'b1101: r = n || z;
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [4:0] psr;
  logic [4:0] psr_next;
  logic       psr_wr;
  logic [4:0] flags_eff;
  logic [2:0] cnt;
  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic [3:0] take_mem;
  logic       push;
  logic       pop;
  logic       cond_p0;

  // Stage p0: flag selection and condition evaluation in the accept cycle
  assign psr_wr    = I_PSR_LOAD || I_STATUS_WE;
  assign psr_next  = I_PSR_LOAD ? I_PSR_WDATA : I_STATUS;
  assign flags_eff = ((FORWARD != 0) && psr_wr) ? psr_next : psr;
  assign cond_p0   = cond_eval(I_COND, flags_eff);

  assign O_COND_READY = (cnt < DEPTH_C);
  assign push         = I_COND_VALID && O_COND_READY;
  assign O_TAKE_VALID = (cnt != 3'd0);
  assign pop          = O_TAKE_VALID && I_TAKE_READY;

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      psr    <= 5'b00000;
      cnt    <= 3'd0;
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
    end else begin
      if (psr_wr) psr <= psr_next;
      if (push) wr_ptr <= (wr_ptr == LAST_C) ? 2'd0 : wr_ptr + 2'd1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_C) ? 2'd0 : rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Stage p1: result storage; entries are qualified by the count, so no reset
  always_ff @(posedge I_CLK) begin
    if (push) take_mem[wr_ptr] <= cond_p0;
  end

  assign O_TAKE  = O_TAKE_VALID && take_mem[rd_ptr];
  assign O_PSR   = psr;
  assign O_COUNT = cnt;

endmodule

// File: tb/tb_cr16_cond_unit.sv
// Directed bench for cr16_cond_unit: a forwarding instance drives all checks,
// a non-forwarding twin on the same inputs covers the old-flags case.
module tb_cr16_cond_unit;

  logic       clk;
  logic       nreset;
  logic [4:0] status;
  logic       status_we;
  logic [4:0] psr_wdata;
  logic       psr_load;
  logic [3:0] cond;
  logic       cond_valid;
  logic       take_ready;

  logic       cond_ready, take_valid, take;
  logic [4:0] psr;
  logic [2:0] count;
  logic       nf_cond_ready, nf_take_valid, nf_take;
  logic [4:0] nf_psr;
  logic [2:0] nf_count;

  int n_checks;
  int n_fail;

  cr16_cond_unit #(.DEPTH(2), .FORWARD(1)) dut (
    .I_CLK(clk), .I_NRESET(nreset), .I_STATUS(status), .I_STATUS_WE(status_we),
    .I_PSR_WDATA(psr_wdata), .I_PSR_LOAD(psr_load), .I_COND(cond),
    .I_COND_VALID(cond_valid), .O_COND_READY(cond_ready), .O_TAKE_VALID(take_valid),
    .O_TAKE(take), .I_TAKE_READY(take_ready), .O_PSR(psr), .O_COUNT(count)
  );

  cr16_cond_unit #(.DEPTH(2), .FORWARD(0)) dut_nf (
    .I_CLK(clk), .I_NRESET(nreset), .I_STATUS(status), .I_STATUS_WE(status_we),
    .I_PSR_WDATA(psr_wdata), .I_PSR_LOAD(psr_load), .I_COND(cond),
    .I_COND_VALID(cond_valid), .O_COND_READY(nf_cond_ready), .O_TAKE_VALID(nf_take_valid),
    .O_TAKE(nf_take), .I_TAKE_READY(take_ready), .O_PSR(nf_psr), .O_COUNT(nf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    status_we  = 1'b0;
    psr_load   = 1'b0;
    cond_valid = 1'b0;
  endtask

  task automatic load_psr(input logic [4:0] v);
    psr_wdata = v;
    psr_load  = 1'b1;
    tick();
    psr_load  = 1'b0;
  endtask

  // Expected results per PSR, bit i = result of condition code i.
  logic [4:0]  sweep_psr [5];
  logic [15:0] sweep_exp [5];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sweep_psr[0] = 5'b00000; sweep_exp[0] = 16'h56AA;
    sweep_psr[1] = 5'b11111; sweep_exp[1] = 16'h6955;
    sweep_psr[2] = 5'b00010; sweep_exp[2] = 16'h5A9A;
    sweep_psr[3] = 5'b10000; sweep_exp[3] = 16'h666A;
    sweep_psr[4] = 5'b01000; sweep_exp[4] = 16'h6AA9;

    nreset = 1'b0; status = '0; psr_wdata = '0; cond = '0; take_ready = 1'b0;
    idle_inputs();
    repeat (3) tick();
    nreset = 1'b1;
    tick();

    // 1: reset state
    check("rst_psr", 16'(psr), 16'h0);
    check("rst_count", 16'(count), 16'h0);
    check("rst_ready", 16'(cond_ready), 16'h1);
    check("rst_tvalid", 16'(take_valid), 16'h0);
    check("rst_take", 16'(take), 16'h0);

    // 2: flag write and condition in the same cycle
    status = 5'b01000; status_we = 1'b1;
    cond = 4'b0000; cond_valid = 1'b1;
    tick();
    idle_inputs();
    check("fwd_tvalid", 16'(take_valid), 16'h1);
    check("fwd_take", 16'(take), 16'h1);
    check("fwd_psr", 16'(psr), 16'h08);
    check("nofwd_tvalid", 16'(nf_take_valid), 16'h1);
    check("nofwd_take", 16'(nf_take), 16'h0);
    take_ready = 1'b1;
    tick();
    check("fwd_drain", 16'(count), 16'h0);

    // 3: all codes against five PSR values, streaming with the consumer ready
    for (int p = 0; p < 5; p++) begin
      load_psr(sweep_psr[p]);
      check("sweep_psr", 16'(psr), 16'(sweep_psr[p]));
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c); cond_valid = 1'b1;
        tick();
        check($sformatf("sweep_p%0d_c%0d", p, c), 16'({take_valid, take}),
              16'({1'b1, sweep_exp[p][c]}));
      end
      cond_valid = 1'b0;
      tick();
      check("sweep_drain", 16'(count), 16'h0);
    end

    // 4: back-pressure fills the FIFO and blocks a third request
    take_ready = 1'b0;
    load_psr(5'b00001);
    cond = 4'b0010; cond_valid = 1'b1; tick();
    cond = 4'b0011; tick();
    check("bp_count2", 16'(count), 16'h2);
    check("bp_ready0", 16'(cond_ready), 16'h0);
    cond = 4'b1110; tick();
    cond_valid = 1'b0;
    check("bp_blocked", 16'(count), 16'h2);
    check("bp_head_hold", 16'(take), 16'h1);
    take_ready = 1'b1;
    check("bp_pop1", 16'(take), 16'h1);
    tick();
    check("bp_pop2", 16'(take), 16'h0);
    check("bp_count1", 16'(count), 16'h1);
    tick();
    check("bp_count0", 16'(count), 16'h0);
    check("bp_empty_take", 16'({take_valid, take}), 16'h0);

    // 5: push and pop together at count 1, walking the pointers around
    take_ready = 1'b0;
    load_psr(5'b00010);
    cond = 4'b0100; cond_valid = 1'b1; tick();
    check("pp_first", 16'({count, take}), 16'({3'd1, 1'b1}));
    take_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      cond = (j % 2 == 0) ? 4'b1010 : 4'b0100;
      tick();
      check($sformatf("pp_%0d", j), 16'({count, take}),
            16'({3'd1, (j % 2 == 0) ? 1'b0 : 1'b1}));
    end
    cond_valid = 1'b0;
    tick();
    check("pp_drain", 16'(count), 16'h0);

    // 6: load beats status write, then async reset drops buffered results
    psr_wdata = 5'b10100; psr_load = 1'b1;
    status = 5'b01000; status_we = 1'b1;
    tick();
    idle_inputs();
    check("prio_psr", 16'(psr), 16'h14);
    take_ready = 1'b0;
    cond = 4'b1110; cond_valid = 1'b1; tick(); tick();
    cond_valid = 1'b0;
    check("ar_count2", 16'(count), 16'h2);
    #2;
    nreset = 1'b0;
    #1;
    check("ar_count", 16'(count), 16'h0);
    check("ar_tvalid", 16'(take_valid), 16'h0);
    check("ar_psr", 16'(psr), 16'h0);
    tick();
    nreset = 1'b1;
    tick();
    check("ar_ready", 16'(cond_ready), 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
